flit_tracker: RTL and testbench

Per-input-channel wormhole packet framer for the NoC router. It generalises the single flit-length countdown to NUM_CH independent channels, each with a valid/ready handshake. Each channel reports header/tail position, remaining body flits, packet completion, packet count and length errors. It sits between the input buffers and the route-compute/switch-allocation stage; is_header_o tells route compute when the current flit carries the address.

---
 rtl/flit_tracker.sv | 108 ++++++++++
 tb/tb_flit_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/flit_tracker.sv
// Per-channel wormhole packet framer: tracks header/body/tail position of each
// input channel's flit stream and counts completed packets.
module flit_tracker #(
   parameter int unsigned NUM_CH              = 5,
   parameter int unsigned LEN_WIDTH           = 8,
   parameter int unsigned LEN_INCLUDES_HEADER = 0,
   parameter int unsigned CNT_WIDTH           = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CH-1:0]             flit_valid_i,
   input  logic [NUM_CH-1:0]             flit_ready_i,
   input  logic [NUM_CH*LEN_WIDTH-1:0]   len_i,
   input  logic [NUM_CH-1:0]             abort_i,
   output logic [NUM_CH-1:0]             is_header_o,
   output logic [NUM_CH-1:0]             is_tail_o,
   output logic [NUM_CH*LEN_WIDTH-1:0]   remaining_o,
   output logic [NUM_CH-1:0]             busy_o,
   output logic [NUM_CH-1:0]             pkt_done_o,
   output logic [NUM_CH*CNT_WIDTH-1:0]   pkt_count_o,
   output logic [NUM_CH-1:0]             len_err_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BODY = 1'b1
   } state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
   localparam bit                   INC_HDR = (LEN_INCLUDES_HEADER != 0);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_t                state_q;
      logic [LEN_WIDTH-1:0]  rem_q;
      logic [CNT_WIDTH-1:0]  cnt_q;
      logic                  done_q;
      logic                  err_q;
      logic [LEN_WIDTH-1:0]  len;
      logic [LEN_WIDTH-1:0]  len_eff;
      logic                  len_zero_err;
      logic                  fire;

      assign len  = len_i[c*LEN_WIDTH +: LEN_WIDTH];
      assign fire = flit_valid_i[c] & flit_ready_i[c];

      // Body flits following the header; a zero length with header counted is flagged
      always_comb begin
         len_eff      = len;
         len_zero_err = 1'b0;
         if (INC_HDR) begin
            len_zero_err = (len == '0);
            if (len != '0) len_eff = len - LEN_ONE;
         end
      end

      // Channel state, remaining counter, completion pulse, counter and error flag
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (abort_i[c]) begin
               state_q <= IDLE;
               rem_q   <= '0;
            end else if (fire) begin
               case (state_q)
                  IDLE: begin
                     if (len_zero_err) err_q <= 1'b1;
                     if (len_eff == '0) begin
                        done_q <= 1'b1;
                        cnt_q  <= cnt_q + CNT_ONE;
                     end else begin
                        rem_q   <= len_eff;
                        state_q <= BODY;
                     end
                  end
                  BODY: begin
                     rem_q <= rem_q - LEN_ONE;
                     if (rem_q == LEN_ONE) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        cnt_q   <= cnt_q + CNT_ONE;
                     end
                  end
                  default: begin
                     state_q <= IDLE;
                     rem_q   <= '0;
                  end
               endcase
            end
         end
      end

      assign is_header_o[c] = (state_q == IDLE);
      assign busy_o[c]      = (state_q == BODY);
      assign is_tail_o[c]   = (state_q == IDLE) ? (len_eff == '0) : (rem_q == LEN_ONE);
      assign pkt_done_o[c]  = done_q;
      assign len_err_o[c]   = err_q;
      assign remaining_o[c*LEN_WIDTH +: LEN_WIDTH] = rem_q;
      assign pkt_count_o[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
   end

endmodule

// File: tb/tb_flit_tracker.sv
// Randomized self-checking bench for flit_tracker: two instances (body-only length
// with 16-bit counters, header-inclusive length with 2-bit counters) share stimulus.
module tb_flit_tracker;

   localparam int unsigned NCH = 5;
   localparam int unsigned LW  = 8;

   logic             clk = 1'b0;
   logic             reset;
   logic [NCH-1:0]   valid, ready, abort;
   logic [NCH*LW-1:0] len;

   logic [NCH-1:0]    hdr0, tail0, busy0, done0, err0;
   logic [NCH*LW-1:0] rem0;
   logic [NCH*16-1:0] cnt0;
   logic [NCH-1:0]    hdr1, tail1, busy1, done1, err1;
   logic [NCH*LW-1:0] rem1;
   logic [NCH*2-1:0]  cnt1;

   flit_tracker #(.NUM_CH(NCH), .LEN_WIDTH(LW), .LEN_INCLUDES_HEADER(0), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .reset(reset), .flit_valid_i(valid), .flit_ready_i(ready), .len_i(len),
      .abort_i(abort), .is_header_o(hdr0), .is_tail_o(tail0), .remaining_o(rem0),
      .busy_o(busy0), .pkt_done_o(done0), .pkt_count_o(cnt0), .len_err_o(err0));

   flit_tracker #(.NUM_CH(NCH), .LEN_WIDTH(LW), .LEN_INCLUDES_HEADER(1), .CNT_WIDTH(2)) dut1 (
      .clk(clk), .reset(reset), .flit_valid_i(valid), .flit_ready_i(ready), .len_i(len),
      .abort_i(abort), .is_header_o(hdr1), .is_tail_o(tail1), .remaining_o(rem1),
      .busy_o(busy1), .pkt_done_o(done1), .pkt_count_o(cnt1), .len_err_o(err1));

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: flits still owed by the current packet, per instance/channel
   int m_left [2][NCH];
   int m_cnt  [2][NCH];
   bit m_done [2][NCH];
   bit m_err  [2][NCH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      else n_pass++;
   endtask

   // Total flits in a packet whose header carries length l
   function automatic int pkt_flits(input int k, input int l);
      if (k == 1) return (l == 0) ? 1 : l;
      return l + 1;
   endfunction

   function automatic int ch_len(input int c);
      logic [NCH*LW-1:0] v;
      v = len;
      return int'(v[c*LW +: LW]);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++) begin
            m_left[k][c] = 0; m_cnt[k][c] = 0; m_done[k][c] = 0; m_err[k][c] = 0;
         end
   endtask

   task automatic model_clock();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++) begin
            m_done[k][c] = 0;
            if (abort[c]) m_left[k][c] = 0;
            else if (valid[c] && ready[c]) begin
               if (m_left[k][c] == 0) begin
                  if (k == 1 && ch_len(c) == 0) m_err[k][c] = 1;
                  m_left[k][c] = pkt_flits(k, ch_len(c)) - 1;
               end else m_left[k][c] = m_left[k][c] - 1;
               if (m_left[k][c] == 0) begin
                  m_done[k][c] = 1;
                  m_cnt[k][c]  = (m_cnt[k][c] + 1) % ((k == 1) ? 4 : 65536);
               end
            end
         end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < NCH; c++) begin
            string p;
            bit    in_body, exp_tail;
            p        = $sformatf("d%0d_c%0d_", k, c);
            in_body  = (m_left[k][c] != 0);
            exp_tail = in_body ? (m_left[k][c] == 1) : (pkt_flits(k, ch_len(c)) == 1);
            check({p, "hdr"},  64'(k ? hdr1[c]  : hdr0[c]),  64'(!in_body));
            check({p, "busy"}, 64'(k ? busy1[c] : busy0[c]), 64'(in_body));
            check({p, "tail"}, 64'(k ? tail1[c] : tail0[c]), 64'(exp_tail));
            check({p, "rem"},  64'(k ? rem1[c*LW +: LW] : rem0[c*LW +: LW]), 64'(m_left[k][c]));
            check({p, "done"}, 64'(k ? done1[c] : done0[c]), 64'(m_done[k][c]));
            check({p, "err"},  64'(k ? err1[c]  : err0[c]),  64'(m_err[k][c]));
            check({p, "cnt"},  64'(k ? 16'(cnt1[c*2 +: 2]) : cnt0[c*16 +: 16]), 64'(m_cnt[k][c]));
         end
   endtask

   task automatic clear_in();
      valid = '0; ready = '0; abort = '0; len = '0;
   endtask

   task automatic set_ch(input int c, input bit v, input bit r, input bit a, input int l);
      valid[c] = v; ready[c] = r; abort[c] = a; len[c*LW +: LW] = LW'(l);
   endtask

   // Check current outputs, then advance one clock in DUT and model
   task automatic step();
      #1;
      check_all();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      step();

      // ch0: header len 3 plus 3 body flits
      set_ch(0, 1, 1, 0, 3);
      repeat (4) step();
      clear_in();
      step();
      check("ch0_count_after_pkt", 64'(cnt0[15:0]), 64'd1);

      // ch1: len 2 with ready toggled 1,0,0,1,1
      for (int i = 0; i < 5; i++) begin
         set_ch(1, 1, (i == 1 || i == 2) ? 1'b0 : 1'b1, 0, 2);
         step();
      end
      clear_in();
      step();

      // ch2: three back-to-back single-flit packets, then a fourth to wrap the 2-bit counter
      set_ch(2, 1, 1, 0, 0);
      repeat (3) step();
      clear_in();
      step();
      check("ch2_len_err_inc_hdr", 64'(err1[2]), 64'd1);
      check("ch2_count_body_only", 64'(cnt0[2*16 +: 16]), 64'd3);
      set_ch(2, 1, 1, 0, 0);
      step();
      clear_in();
      step();
      check("ch2_count_wrap", 64'(cnt1[2*2 +: 2]), 64'd0);

      // ch3: header len 5, two body flits, abort with fire, then a fresh header
      set_ch(3, 1, 1, 0, 5);
      repeat (3) step();
      set_ch(3, 1, 1, 1, 5);
      step();
      check("ch3_abort_hdr", 64'(hdr0[3]), 64'd1);
      set_ch(3, 1, 1, 0, 0);
      step();
      clear_in();
      step();

      // ch4: async reset mid-packet, away from any clock edge
      set_ch(4, 1, 1, 0, 7);
      step();
      clear_in();
      check("ch4_rem_before_reset", 64'(rem0[4*LW +: LW]), 64'd7);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check("ch4_async_busy", 64'(busy0[4]), 64'd0);
      check("ch4_async_rem", 64'(rem0[4*LW +: LW]), 64'd0);
      check_all();
      #1 reset = 1'b0;
      step();

      // Random traffic on all channels
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            int l;
            l = ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 4));
            set_ch(c, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 39) == 0, l);
         end
         step();
      end
      clear_in();
      step();
      check_all();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
